if_prefetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the MIPS pipeline.
- Holds the fetch PC and an async-read instruction RAM with a loader write port.
- Decouples fetch from decode through a small prefetch queue. Decode consumes {instruction, pc, pc+4} entries via a valid/ready handshake.
- Adds jump flush, halt, and memory-load lockout beyond the previous single-register fetch stage.

---
 rtl/if_pkg.sv | 12 +
 rtl/if_prefetch_unit_if.sv | 34 +++
 rtl/if_prefetch_queue.sv | 74 +++++++
 rtl/xilinx_one_port_ram_async.sv | 19 +
 rtl/if_prefetch_unit.sv | 81 ++++++++
 tb/tb_if_prefetch_unit.sv | 188 ++++++++++++++++++
 6 files changed

// File: rtl/if_pkg.sv
// Shared constants and entry type for the instruction-fetch stage.
package if_pkg;
  localparam int unsigned NB_DATA  = 32;
  localparam int unsigned NB_ADDR  = 8;
  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned RESET_PC = 0;

  typedef struct packed {
    logic [NB_DATA-1:0] instr;
    logic [NB_DATA-1:0] pc;
  } if_entry_t;
endpackage

// File: rtl/if_prefetch_unit_if.sv
// Loader / redirect / decode-handshake bundle between the fetch stage and its neighbours.
interface if_prefetch_unit_if
  import if_pkg::*;
#(
  parameter int unsigned NB_DATA     = if_pkg::NB_DATA,
  parameter int unsigned NB_ADDR     = if_pkg::NB_ADDR,
  parameter int unsigned QUEUE_DEPTH = 4
);
  localparam int unsigned NB_COUNT = $clog2(QUEUE_DEPTH) + 1;

  logic                i_we;
  logic [NB_ADDR-1:0]  i_waddr;
  logic [NB_DATA-1:0]  i_wdata;
  logic                i_jump;
  logic [NB_DATA-1:0]  i_addr2jump;
  logic                i_halt;
  logic                i_ready;
  logic                o_valid;
  logic [NB_DATA-1:0]  o_instruction;
  logic [NB_DATA-1:0]  o_pcounter;
  logic [NB_DATA-1:0]  o_pcounter4;
  logic [NB_DATA-1:0]  o_fetch_pc;
  logic [NB_COUNT-1:0] o_count;

  modport master (
    output i_we, i_waddr, i_wdata, i_jump, i_addr2jump, i_halt, i_ready,
    input  o_valid, o_instruction, o_pcounter, o_pcounter4, o_fetch_pc, o_count
  );

  modport slave (
    input  i_we, i_waddr, i_wdata, i_jump, i_addr2jump, i_halt, i_ready,
    output o_valid, o_instruction, o_pcounter, o_pcounter4, o_fetch_pc, o_count
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Circular prefetch FIFO with synchronous flush, simultaneous push/pop and occupancy count.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = if_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     wdata,
  output entry_t                     rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned NB_PTR = $clog2(DEPTH);
  localparam int unsigned NB_CNT = NB_PTR + 1;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [NB_PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [NB_PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NB_CNT-1:0]   count_q, count_d;
  logic                do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < NB_CNT'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset; an empty queue masks it to zero on read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/xilinx_one_port_ram_async.sv
// Single-port RAM: synchronous write, asynchronous read at the same address.
module xilinx_one_port_ram_async #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) ram[addr] <= din;
  end

  assign dout = ram[addr];
endmodule

// File: rtl/if_prefetch_unit.sv
// MIPS instruction-fetch stage: fetch PC, instruction RAM with loader port, prefetch queue to decode.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int unsigned        NB_DATA     = if_pkg::NB_DATA,
  parameter int unsigned        NB_ADDR     = if_pkg::NB_ADDR,
  parameter int unsigned        QUEUE_DEPTH = 4,
  parameter logic [NB_DATA-1:0] RESET_PC    = NB_DATA'(if_pkg::RESET_PC)
) (
  input logic               clk,
  input logic               i_rst_n,
  if_prefetch_unit_if.slave bus
);
  localparam int unsigned NB_COUNT = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [NB_DATA-1:0] instr;
    logic [NB_DATA-1:0] pc;
  } entry_t;

  logic [NB_DATA-1:0]  fetch_pc_q, fetch_pc_d;
  logic [NB_ADDR-1:0]  ram_addr;
  logic [NB_DATA-1:0]  ram_dout;
  logic                q_empty;
  logic [NB_COUNT-1:0] q_count;
  entry_t              q_head, q_wdata;
  logic                pop, fetch_en, full;

  // The RAM has one address port: the loader owns it while i_we is high, which is why fetch pauses.
  assign ram_addr = bus.i_we ? bus.i_waddr : fetch_pc_q[NB_ADDR+1:2];

  xilinx_one_port_ram_async #(
    .ADDR_WIDTH (NB_ADDR),
    .DATA_WIDTH (NB_DATA)
  ) u_ram (
    .clk  (clk),
    .we   (bus.i_we),
    .addr (ram_addr),
    .din  (bus.i_wdata),
    .dout (ram_dout)
  );

  assign full     = (q_count == NB_COUNT'(QUEUE_DEPTH));
  assign pop      = !q_empty && bus.i_ready && !bus.i_halt && !bus.i_jump;
  assign fetch_en = !bus.i_we && !bus.i_halt && !bus.i_jump && (!full || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.i_jump)    fetch_pc_d = bus.i_addr2jump & ~NB_DATA'(3);
    else if (fetch_en) fetch_pc_d = fetch_pc_q + NB_DATA'(PC_STEP);
    q_wdata.instr = ram_dout;
    q_wdata.pc    = fetch_pc_q;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) fetch_pc_q <= RESET_PC;
    else          fetch_pc_q <= fetch_pc_d;
  end

  if_prefetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst_n (i_rst_n),
    .flush (bus.i_jump),
    .push  (fetch_en),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_head),
    .empty (q_empty),
    .count (q_count)
  );

  assign bus.o_valid       = !q_empty;
  assign bus.o_instruction = q_head.instr;
  assign bus.o_pcounter    = q_head.pc;
  assign bus.o_pcounter4   = q_empty ? '0 : q_head.pc + NB_DATA'(PC_STEP);
  assign bus.o_fetch_pc    = fetch_pc_q;
  assign bus.o_count       = q_count;
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed testbench for if_prefetch_unit: load, stream, backpressure, jump, halt, reset, wrap.
module tb_if_prefetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  if_prefetch_unit_if #(.NB_DATA(32), .NB_ADDR(8), .QUEUE_DEPTH(4)) bus ();

  if_prefetch_unit #(
    .NB_DATA     (32),
    .NB_ADDR     (8),
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target, input logic rdy);
    bus.i_jump = 1'b1; bus.i_addr2jump = target; bus.i_ready = rdy;
    step();
    bus.i_jump = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_we = 1'b0; bus.i_waddr = '0; bus.i_wdata = '0; bus.i_jump = 1'b0;
    bus.i_addr2jump = '0; bus.i_halt = 1'b1; bus.i_ready = 1'b0;
    #12;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %h exp 0", bus.o_valid); end
    tests++; if (bus.o_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", bus.o_count); end
    tests++; if (bus.o_fetch_pc !== 32'h0) begin fails++; $display("FAIL reset_fetch_pc got %h exp 0", bus.o_fetch_pc); end
    tests++; if (bus.o_instruction !== 32'h0 || bus.o_pcounter !== 32'h0 || bus.o_pcounter4 !== 32'h0) begin
      fails++; $display("FAIL reset_head got %h/%h/%h exp 0/0/0", bus.o_instruction, bus.o_pcounter, bus.o_pcounter4); end
    @(negedge clk) rst_n = 1'b1;
    step();
    tests++; if (bus.o_count !== 3'd0 || bus.o_fetch_pc !== 32'h0) begin
      fails++; $display("FAIL reset_halted got cnt %0d pc %h exp 0 0", bus.o_count, bus.o_fetch_pc); end
    bus.i_halt = 1'b0;
  endtask

  task automatic load_ram();
    logic [31:0] w;
    for (int k = 0; k < 16; k++) begin
      w = 32'h11 + 32'(k);
      bus.i_we = 1'b1; bus.i_waddr = 8'(k); bus.i_wdata = w;
      step();
    end
    bus.i_we = 1'b1; bus.i_waddr = 8'hFF; bus.i_wdata = 32'hAA;
    step();
    tests++; if (bus.o_count !== 3'd0 || bus.o_fetch_pc !== 32'h0) begin
      fails++; $display("FAIL load_no_fetch got cnt %0d pc %h exp 0 0", bus.o_count, bus.o_fetch_pc); end
  endtask

  task automatic test_stream();
    bus.i_we = 1'b0; bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h11 + 32'(k) ||
                   bus.o_pcounter !== 32'(4*k) || bus.o_pcounter4 !== 32'(4*k+4)) begin
        fails++; $display("FAIL stream[%0d] got v%h %h %h %h exp v1 %h %h %h", k, bus.o_valid,
                          bus.o_instruction, bus.o_pcounter, bus.o_pcounter4, 32'h11 + 32'(k), 4*k, 4*k+4); end
    end
  endtask

  task automatic test_backpressure();
    redirect(32'h0, 1'b0);
    repeat (6) step();
    tests++; if (bus.o_count !== 3'd4 || bus.o_fetch_pc !== 32'h10) begin
      fails++; $display("FAIL bp_full got cnt %0d pc %h exp 4 10", bus.o_count, bus.o_fetch_pc); end
    tests++; if (bus.o_instruction !== 32'h11 || bus.o_pcounter !== 32'h0) begin
      fails++; $display("FAIL bp_head got %h %h exp 11 0", bus.o_instruction, bus.o_pcounter); end
    bus.i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      tests++; if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h11 + 32'(k) ||
                   bus.o_pcounter !== 32'(4*k) || bus.o_count !== 3'd4) begin
        fails++; $display("FAIL bp_drain[%0d] got v%h %h %h cnt %0d exp v1 %h %h 4", k, bus.o_valid,
                          bus.o_instruction, bus.o_pcounter, bus.o_count, 32'h11 + 32'(k), 4*k); end
    end
    tests++; if (bus.o_fetch_pc !== 32'h20) begin
      fails++; $display("FAIL bp_resume got %h exp 20", bus.o_fetch_pc); end
  endtask

  task automatic test_jump();
    redirect(32'h0, 1'b0);
    repeat (3) step();
    tests++; if (bus.o_count !== 3'd3) begin fails++; $display("FAIL jump_pre_count got %0d exp 3", bus.o_count); end
    redirect(32'h20, 1'b1);
    tests++; if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0 || bus.o_fetch_pc !== 32'h20 || bus.o_instruction !== 32'h0) begin
      fails++; $display("FAIL jump_flush got v%h cnt %0d pc %h ins %h exp v0 0 20 0", bus.o_valid,
                        bus.o_count, bus.o_fetch_pc, bus.o_instruction); end
    step();
    tests++; if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h19 || bus.o_pcounter !== 32'h20 || bus.o_pcounter4 !== 32'h24) begin
      fails++; $display("FAIL jump_target got v%h %h %h %h exp v1 19 20 24", bus.o_valid,
                        bus.o_instruction, bus.o_pcounter, bus.o_pcounter4); end
    redirect(32'h27, 1'b1);
    tests++; if (bus.o_fetch_pc !== 32'h24) begin fails++; $display("FAIL jump_align got %h exp 24", bus.o_fetch_pc); end
    step();
    tests++; if (bus.o_instruction !== 32'h1A || bus.o_pcounter !== 32'h24) begin
      fails++; $display("FAIL jump_align_head got %h %h exp 1a 24", bus.o_instruction, bus.o_pcounter); end
  endtask

  task automatic test_jump_halt();
    bus.i_halt = 1'b1;
    redirect(32'h10, 1'b1);
    tests++; if (bus.o_count !== 3'd0 || bus.o_fetch_pc !== 32'h10) begin
      fails++; $display("FAIL jh_redirect got cnt %0d pc %h exp 0 10", bus.o_count, bus.o_fetch_pc); end
    step();
    tests++; if (bus.o_valid !== 1'b0 || bus.o_fetch_pc !== 32'h10) begin
      fails++; $display("FAIL jh_frozen got v%h pc %h exp v0 10", bus.o_valid, bus.o_fetch_pc); end
    bus.i_halt = 1'b0;
    step();
    tests++; if (bus.o_instruction !== 32'h15 || bus.o_pcounter !== 32'h10) begin
      fails++; $display("FAIL jh_resume got %h %h exp 15 10", bus.o_instruction, bus.o_pcounter); end
  endtask

  task automatic test_halt();
    redirect(32'h0, 1'b1);
    repeat (2) step();
    bus.i_halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h12 || bus.o_pcounter !== 32'h4 ||
                   bus.o_count !== 3'd1 || bus.o_fetch_pc !== 32'h8) begin
        fails++; $display("FAIL halt_hold[%0d] got v%h %h %h cnt %0d pc %h exp v1 12 4 1 8", k, bus.o_valid,
                          bus.o_instruction, bus.o_pcounter, bus.o_count, bus.o_fetch_pc); end
    end
    bus.i_halt = 1'b0;
    step();
    tests++; if (bus.o_instruction !== 32'h13 || bus.o_pcounter !== 32'h8) begin
      fails++; $display("FAIL halt_resume got %h %h exp 13 8", bus.o_instruction, bus.o_pcounter); end
  endtask

  task automatic test_async_reset();
    redirect(32'h0, 1'b0);
    repeat (4) step();
    tests++; if (bus.o_count !== 3'd4) begin fails++; $display("FAIL ar_full got %0d exp 4", bus.o_count); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0 || bus.o_fetch_pc !== 32'h0) begin
      fails++; $display("FAIL ar_immediate got v%h cnt %0d pc %h exp v0 0 0", bus.o_valid, bus.o_count, bus.o_fetch_pc); end
    @(negedge clk) rst_n = 1'b1;
    step();
    tests++; if (bus.o_valid !== 1'b1 || bus.o_instruction !== 32'h11 || bus.o_pcounter !== 32'h0) begin
      fails++; $display("FAIL ar_restart got v%h %h %h exp v1 11 0", bus.o_valid, bus.o_instruction, bus.o_pcounter); end
  endtask

  task automatic test_wrap();
    redirect(32'h3FC, 1'b0);
    step();
    tests++; if (bus.o_instruction !== 32'hAA || bus.o_pcounter !== 32'h3FC || bus.o_pcounter4 !== 32'h400) begin
      fails++; $display("FAIL wrap_last got %h %h %h exp aa 3fc 400", bus.o_instruction, bus.o_pcounter, bus.o_pcounter4); end
    step();
    bus.i_ready = 1'b1;
    step();
    tests++; if (bus.o_instruction !== 32'h11 || bus.o_pcounter !== 32'h400 || bus.o_pcounter4 !== 32'h404) begin
      fails++; $display("FAIL wrap_index got %h %h %h exp 11 400 404", bus.o_instruction, bus.o_pcounter, bus.o_pcounter4); end
  endtask

  initial begin
    test_reset();
    load_ram();
    test_stream();
    test_backpressure();
    test_jump();
    test_jump_halt();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
